// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - UART framed image loader driving the instruction-memory write port and core reset
module uart_boot_loader #(
    parameter int CLK_DIV    = 434,
    parameter int MAX_WORDS  = 512,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_i,
    output logic [ADDR_WIDTH-1:0] inst_addr_o,
    output logic [31:0]           inst_data_o,
    output logic                  inst_w_enable_o,
    output logic                  core_rst_n_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {SYNC, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;

    rx_state_t     rx_state;
    logic          rx_meta, rx_sync, rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    rx_byte;
    logic          rx_valid, rx_ferr;

    // Synchronizer flops reset high so the idle line never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_meta  <= rx_i;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        cnt      <= HALF;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (rx_sync) begin
                        rx_state <= RX_IDLE;
                    end else begin
                        cnt      <= FULL;
                        bit_idx  <= '0;
                        rx_state <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        rx_byte <= {rx_sync, rx_byte[7:1]};
                        cnt     <= FULL;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                    end
                end
                default: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        rx_valid <= rx_sync;
                        rx_ferr  <= !rx_sync;
                        rx_state <= RX_IDLE;
                    end
                end
            endcase
        end
    end

    state_t      state;
    logic [7:0]  len_l;
    logic [15:0] n_words, word_cnt;
    logic [1:0]  byte_idx;
    logic [31:0] word_buf;
    logic [7:0]  sum;
    logic [15:0] len_word;

    assign len_word = {rx_byte, len_l};
    assign busy_o   = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= SYNC;
            len_l           <= '0;
            n_words         <= '0;
            word_cnt        <= '0;
            byte_idx        <= '0;
            word_buf        <= '0;
            sum             <= '0;
            inst_addr_o     <= '0;
            inst_data_o     <= '0;
            inst_w_enable_o <= 1'b0;
            core_rst_n_o    <= 1'b0;
            done_o          <= 1'b0;
            err_o           <= 1'b0;
        end else begin
            inst_w_enable_o <= 1'b0;
            // A framing error aborts the frame before any partial word can be written.
            if (rx_ferr && state != DONE && state != ERR) begin
                state <= ERR;
                err_o <= 1'b1;
            end else if (rx_valid) begin
                case (state)
                    SYNC: begin
                        if (rx_byte == 8'hA5) begin
                            state <= LEN0;
                            sum   <= '0;
                        end
                    end
                    LEN0: begin
                        len_l <= rx_byte;
                        state <= LEN1;
                    end
                    LEN1: begin
                        n_words  <= len_word;
                        word_cnt <= '0;
                        byte_idx <= '0;
                        if (len_word > 16'(MAX_WORDS)) begin
                            state <= ERR;
                            err_o <= 1'b1;
                        end else if (len_word == 16'd0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        sum      <= sum + rx_byte;
                        word_buf <= {rx_byte, word_buf[31:8]};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            inst_w_enable_o <= 1'b1;
                            inst_data_o     <= {rx_byte, word_buf[31:8]};
                            inst_addr_o     <= ADDR_WIDTH'({word_cnt, 2'b00});
                            word_cnt        <= word_cnt + 16'd1;
                            if (word_cnt + 16'd1 == n_words) state <= CSUM;
                        end
                    end
                    CSUM: begin
                        if (rx_byte == sum) begin
                            state        <= DONE;
                            done_o       <= 1'b1;
                            core_rst_n_o <= 1'b1;
                        end else begin
                            state <= ERR;
                            err_o <= 1'b1;
                        end
                    end
                    ERR: begin
                        if (rx_byte == 8'hA5) begin
                            state <= LEN0;
                            err_o <= 1'b0;
                            sum   <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
Serial boot loader sitting directly upstream of the instruction ROM/RAM write port and the core reset. It receives a framed program image over a UART RX line. It assembles little-endian 32-bit words and issues one instruction-memory write per word. It holds the core in reset until a frame with a valid checksum completes.

Parameters:
CLK_DIV, 434, clock cycles per UART bit (must be >= 4)
MAX_WORDS, 512, largest accepted word count; a larger length field is an error
ADDR_WIDTH, 32, width of inst_addr_o (byte address)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
rx_i  input  1  UART RX line, idle high, asynchronous to clk
inst_addr_o  output  ADDR_WIDTH  byte address of the current write; word-aligned
inst_data_o  output  32  instruction word to write
inst_w_enable_o  output  1  one-cycle write strobe
core_rst_n_o  output  1  active-low reset to the core; low until load completes
busy_o  output  1  high while a frame is in progress (state not SYNC/DONE/ERR)
done_o  output  1  load finished with a good checksum (sticky)
err_o  output  1  frame or protocol error (sticky until next sync)

Behaviour:
- Reset: the reset is asynchronous and active-low (rst_n).
  - While reset is asserted, all outputs are 0, including core_rst_n_o.
  - The FSM enters SYNC and all counters clear.
  - Reset mid-frame discards the partial frame. Memory already written is not touched.
- RX front end:
  - rx_i passes through a 2-flop synchronizer.
  - A start is detected on a synchronized high-to-low transition while the receiver is idle.
  - Sampling:
    - Start bit is sampled at CLK_DIV/2 cycles after detection. If it is high there, treat it as a glitch and return to idle with no error.
    - 8 data bits are sampled LSB first, each CLK_DIV cycles apart.
    - The stop bit is then sampled.
  - Stop bit low: framing error. The FSM goes to ERR.
  - Valid byte: rx_valid is asserted for 1 cycle internally, 1 cycle after the stop-bit sample. The receiver is idle again right after the stop sample.
- Frame format (bytes):
  - 0xA5 sync byte.
  - LEN_L, LEN_H: 16-bit word count N, little-endian.
  - N*4 data bytes. Each word is little-endian; the first byte goes to bits [7:0].
  - CSUM: 8-bit sum, modulo 256, of all data bytes only.
- Frame FSM:
  - SYNC: on byte 0xA5 go to LEN0. Any other byte is ignored.
  - LEN0: latch LEN_L, go to LEN1.
  - LEN1: latch LEN_H.
    - N > MAX_WORDS: go to ERR.
    - N == 0: go to CSUM.
    - Otherwise go to DATA with word_cnt = 0 and byte_idx = 0.
  - DATA: shift each byte into the word buffer and add it to the running sum (8-bit wrap).
    - On the 4th byte, assert inst_w_enable_o for exactly 1 cycle, in the cycle after that byte's rx_valid.
    - In that cycle, inst_data_o holds the assembled word and inst_addr_o = word_cnt*4. Both keep their values until the next write.
    - word_cnt then increments. When word_cnt reaches N, go to CSUM.
  - CSUM: compare the received byte with the running sum.
    - Equal: go to DONE.
    - Not equal: go to ERR. Words already written stay written.
  - DONE: done_o = 1 and core_rst_n_o = 1 from the cycle after the CSUM byte's rx_valid. Further RX bytes are ignored until rst_n.
  - ERR: err_o = 1 and core_rst_n_o stays 0. A received 0xA5 clears err_o, clears the sum, and goes to LEN0.
- Address arithmetic: inst_addr_o = {word_cnt, 2'b00}, truncated to ADDR_WIDTH. Loading always starts at address 0.
- Simultaneous events: the write strobe and a new start-bit detection can coincide; they are independent and the RX front end is never stalled. A stop-bit framing error during DATA goes to ERR and suppresses the write for the partial word.
- Throughput: one write per 4 bytes, with no backpressure; the memory accepts a write every cycle.

Test Plan:
- Good load (CLK_DIV=8): send A5 02 00 13 00 00 00 93 00 10 00 CSUM=0xB6.
  - Writes addr 0x0 data 0x00000013, then addr 0x4 data 0x00100093.
  - done_o=1, core_rst_n_o=1, err_o=0.
- Bad checksum: same frame with CSUM=0xB7.
  - Both writes occur; err_o=1, core_rst_n_o=0.
  - Then resend the full good frame: err_o clears, done_o=1.
- Zero/oversize length:
  - A5 00 00 00: done_o=1 with no writes.
  - After reset, A5 01 02 (N=513, MAX_WORDS=512): err_o=1 with no writes.
- Noise and framing: send 0x3C before the sync byte; it is ignored.
  - A 2-cycle low glitch on rx_i: no byte is received and no error occurs.
  - A byte with stop bit = 0 during DATA: err_o=1, and the partial word is not written.
- Reset mid-frame: assert rst_n low after 5 data bytes.
  - All outputs go to 0 asynchronously.
  - A following good frame loads correctly from address 0.
